// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for pipe_stage_reg: upstream in_*, downstream out_*, flush and bubble count.
// master = surrounding pipeline logic, slave = the stage register itself.
interface pipe_stage_reg_if #(
    parameter int DATA_W     = 32,
    parameter int NUM_FIELDS = 5,
    parameter int CNT_W      = 16
);
    logic                         flush;
    logic                         in_valid;
    logic                         in_ready;
    logic [DATA_W*NUM_FIELDS-1:0] in_data;
    logic                         out_valid;
    logic                         out_ready;
    logic [DATA_W*NUM_FIELDS-1:0] out_data;
    logic [CNT_W-1:0]             bubble_cnt;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, bubble_cnt
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, bubble_cnt
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with flush, zeroed bubbles and a saturating bubble counter.
// Define PIPE_STAGE_SKID_EN to add a one-entry skid buffer that registers in_ready.
module pipe_stage_reg #(
    parameter int DATA_W     = 32,
    parameter int NUM_FIELDS = 5,
    parameter int CNT_W      = 16
) (
    input logic             clk,
    input logic             reset,
    pipe_stage_reg_if.slave bus
);
    localparam int W = DATA_W * NUM_FIELDS;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    logic             vld_p1    = 1'b0;
    logic [W-1:0]     data_p1   = '0;
    logic [CNT_W-1:0] bubble_p1 = '0;

    logic accept;
    logic drain;

    assign accept = bus.in_valid && bus.in_ready;
    assign drain  = vld_p1 && bus.out_ready;

`ifdef PIPE_STAGE_SKID_EN
    // ---- stage p0: skid slot, catches one entry while the main register is stalled
    logic         skid_vld_p0  = 1'b0;
    logic [W-1:0] skid_data_p0 = '0;

    assign bus.in_ready = !skid_vld_p0;

    // ---- stage p1: main register; a waiting skid entry always goes first to keep order
    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            vld_p1       <= 1'b0;
            data_p1      <= '0;
            skid_vld_p0  <= 1'b0;
            skid_data_p0 <= '0;
        end else if (!vld_p1 || drain) begin
            if (skid_vld_p0) begin
                vld_p1       <= 1'b1;
                data_p1      <= skid_data_p0;
                skid_vld_p0  <= 1'b0;
                skid_data_p0 <= '0;
            end else if (accept) begin
                vld_p1  <= 1'b1;
                data_p1 <= bus.in_data;
            end else begin
                vld_p1  <= 1'b0;
                data_p1 <= '0;
            end
        end else if (accept) begin
            skid_vld_p0  <= 1'b1;
            skid_data_p0 <= bus.in_data;
        end
    end
`else
    assign bus.in_ready = !vld_p1 || bus.out_ready;

    // ---- stage p1: main register; drained slots are zeroed so a bubble reads as NOP
    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
        end else if (accept) begin
            vld_p1  <= 1'b1;
            data_p1 <= bus.in_data;
        end else if (drain) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
        end
    end
`endif

    // A bubble is a cycle where downstream was ready but nothing was offered.
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_p1 <= '0;
        end else if (!vld_p1 && bus.out_ready) begin
            bubble_p1 <= sat_inc(bubble_p1);
        end
    end

    assign bus.out_valid  = vld_p1;
    assign bus.out_data   = data_p1;
    assign bus.bubble_cnt = bubble_p1;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed steps then random traffic against a queue-based model.
// Honours PIPE_STAGE_SKID_EN so the same bench covers both builds.
module tb_pipe_stage_reg;
    localparam int DATA_W     = 32;
    localparam int NUM_FIELDS = 5;
    localparam int CNT_W      = 4;
    localparam int DW         = DATA_W * NUM_FIELDS;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;
`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;

    pipe_stage_reg_if #(.DATA_W(DATA_W), .NUM_FIELDS(NUM_FIELDS), .CNT_W(CNT_W)) bus ();

    pipe_stage_reg #(.DATA_W(DATA_W), .NUM_FIELDS(NUM_FIELDS), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Entries the stage should be holding, oldest first; bubble count kept as a plain int.
    logic [DW-1:0]     q[$];
    int                cnt = 0;
    logic [DATA_W-1:0] seen[$];
    bit                last_acc;

    function automatic logic [DW-1:0] f0(input logic [DATA_W-1:0] v);
        return {{(DW-DATA_W){1'b0}}, v};
    endfunction

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] d;
        for (int i = 0; i < NUM_FIELDS; i++) d[i*DATA_W +: DATA_W] = $urandom;
        return d;
    endfunction

    function automatic bit model_in_ready(input bit ordy);
        if (SKID) return q.size() < 2;
        return (q.size() == 0) || ordy;
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit r, input bit f, input bit iv, input logic [DW-1:0] d, input bit ordy);
        reset        = r;
        bus.flush    = f;
        bus.in_valid = iv;
        bus.in_data  = d;
        bus.out_ready = ordy;
    endtask

    task automatic tick();
        bit            exp_rdy, pop, r, fl, iv, ordy;
        logic [DW-1:0] din;
        #1;
        r    = reset;
        fl   = bus.flush;
        iv   = bus.in_valid;
        ordy = bus.out_ready;
        din  = bus.in_data;
        exp_rdy = model_in_ready(ordy);
        check("in_ready", DW'(bus.in_ready), DW'(exp_rdy));
        last_acc = iv && exp_rdy;
        pop = (q.size() > 0) && ordy;
        if (bus.out_valid && ordy && !r) seen.push_back(bus.out_data[DATA_W-1:0]);
        @(posedge clk);
        if (r) begin
            q.delete();
            cnt = 0;
        end else begin
            if (q.size() == 0 && ordy && cnt < CNT_MAX) cnt++;
            if (fl) q.delete();
            else begin
                if (pop) void'(q.pop_front());
                if (last_acc) q.push_back(din);
            end
        end
        #1;
        check("out_valid", DW'(bus.out_valid), DW'(q.size() > 0));
        check("out_data", bus.out_data, (q.size() > 0) ? q[0] : '0);
        check("bubble_cnt", DW'(bus.bubble_cnt), DW'(cnt));
    endtask

    initial begin
        int idx;
        bit pat[6];
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        #1;
        check("init_valid", DW'(bus.out_valid), DW'(0));
        check("init_data", bus.out_data, '0);
        check("init_cnt", DW'(bus.bubble_cnt), DW'(0));

        // Reset, then one instruction with downstream ready
        drive(1'b1, 1'b0, 1'b0, '0, 1'b1); tick();
        drive(1'b0, 1'b0, 1'b1, f0(32'h8C220004), 1'b1); tick();
        check("first_valid", DW'(bus.out_valid), DW'(1));
        check("first_f0", DW'(bus.out_data[DATA_W-1:0]), f0(32'h8C220004));
        drive(1'b0, 1'b0, 1'b0, '0, 1'b1); tick();

        // Four entries against a toggling out_ready
        seen.delete();
        idx = 0;
        for (int c = 0; c < 16; c++) begin
            drive(1'b0, 1'b0, idx < 4, f0(DATA_W'(idx + 1)), (c < 6) ? pat[c] : 1'b1);
            tick();
            if (last_acc) idx++;
        end
        check("seq_len", DW'(seen.size()), DW'(4));
        for (int i = 0; i < 4 && i < seen.size(); i++)
            check("seq_item", DW'(seen[i]), DW'(i + 1));

        // Flush kills both the held entry and the one accepted in the flush cycle
        drive(1'b0, 1'b0, 1'b1, f0(32'hAAAA5555), 1'b0); tick();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0); tick();
        check("hold_f0", DW'(bus.out_data[DATA_W-1:0]), f0(32'hAAAA5555));
        drive(1'b0, 1'b1, 1'b1, f0(32'h12345678), 1'b1); tick();
        check("flush_valid", DW'(bus.out_valid), DW'(0));
        check("flush_data", bus.out_data, '0);

        // Reset mid-operation with a held entry and bubble_cnt=7
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0); tick();
        for (int c = 0; c < 7; c++) begin
            drive(1'b0, 1'b0, 1'b0, '0, 1'b1); tick();
        end
        drive(1'b0, 1'b0, 1'b1, f0(32'h55), 1'b0); tick();
        check("pre_rst_cnt", DW'(bus.bubble_cnt), DW'(7));
        check("pre_rst_valid", DW'(bus.out_valid), DW'(1));
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0); tick();
        check("rst_valid", DW'(bus.out_valid), DW'(0));
        check("rst_data", bus.out_data, '0);
        check("rst_cnt", DW'(bus.bubble_cnt), DW'(0));
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        #1;
        check("rst_in_ready", DW'(bus.in_ready), DW'(1));

        // Bubble counter saturation
        drive(1'b1, 1'b0, 1'b0, '0, 1'b1); tick();
        for (int c = 0; c < 20; c++) begin
            drive(1'b0, 1'b0, 1'b0, '0, 1'b1); tick();
        end
        check("cnt_sat", DW'(bus.bubble_cnt), DW'(15));

        // Stall with a second entry offered
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b1, f0(32'h1), 1'b0); tick();
`ifdef PIPE_STAGE_SKID_EN
        drive(1'b0, 1'b0, 1'b1, f0(32'h2), 1'b0); tick();
        check("skid_in_ready", DW'(bus.in_ready), DW'(0));
        check("skid_f0_a", DW'(bus.out_data[DATA_W-1:0]), f0(32'h1));
        drive(1'b0, 1'b0, 1'b0, '0, 1'b1); tick();
        check("skid_f0_b", DW'(bus.out_data[DATA_W-1:0]), f0(32'h2));
        check("skid_ready_back", DW'(bus.in_ready), DW'(1));
        tick();
        check("skid_empty", DW'(bus.out_valid), DW'(0));
`else
        drive(1'b0, 1'b0, 1'b1, f0(32'h2), 1'b0);
        #1;
        check("stall_in_ready", DW'(bus.in_ready), DW'(0));
        tick();
        check("stall_f0", DW'(bus.out_data[DATA_W-1:0]), f0(32'h1));
        drive(1'b0, 1'b0, 1'b1, f0(32'h2), 1'b1); tick();
        check("replace_f0", DW'(bus.out_data[DATA_W-1:0]), f0(32'h2));
`endif

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(63) == 0, $urandom_range(15) == 0, $urandom_range(1) == 1,
                  rnd_data(), $urandom_range(3) != 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter: DATA_W, 32, width of one field in bits.
REQ-002 Parameter: NUM_FIELDS, 5, number of fields carried (e.g. IR, RD1, RD2, EXT, PC4).
REQ-003 Parameter: CNT_W, 16, width of bubble counter.
REQ-004 Port: clk  input  1  clock, all state updates on rising edge.
REQ-005 Port: reset  input  1  reset, synchronous, active-high.
REQ-006 Port: flush  input  1  discard all held entries (branch/jump kill, hazard clear).
REQ-007 Port: in_valid  input  1  upstream presents an entry.
REQ-008 Port: in_ready  output  1  stage accepts entry this cycle.
REQ-009 Port: in_data  input  DATA_W*NUM_FIELDS  packed fields, field k at bits [k*DATA_W +: DATA_W].
REQ-010 Port: out_valid  output  1  stage holds a valid entry.
REQ-011 Port: out_ready  input  1  downstream consumes entry this cycle.
REQ-012 Port: out_data  output  DATA_W*NUM_FIELDS  registered fields.
REQ-013 Port: bubble_cnt  output  CNT_W  saturating count of bubble cycles.

Function
REQ-014 Transfer in: in_valid && in_ready at a rising edge; transfer out: out_valid && out_ready.
REQ-015 Latency: accepted entry appears on out_data/out_valid exactly 1 cycle after acceptance (main register empty or draining).
REQ-016 out_data SHALL be all-zero whenever out_valid=0 (bubble = NOP instruction 0x00000000).
REQ-017 Without skid: in_ready = !out_valid || out_ready (combinational pass-through of downstream ready).
REQ-018 Hold: out_valid=1 and out_ready=0 -> out_data and out_valid unchanged, no entry lost or duplicated.
REQ-019 Simultaneous out transfer and in transfer -> new entry replaces old in same edge, out_valid stays 1.
REQ-020 Out transfer with no in transfer -> out_valid=0, out_data=0 next cycle.
REQ-021 flush=1 -> next cycle out_valid=0, out_data=0, all internal entries invalid; any in transfer in the flush cycle is discarded.
REQ-022 in_ready during flush cycle follows normal rules (upstream sees acceptance; entry is killed).
REQ-023 bubble_cnt increments by 1 each cycle with out_valid=0 and out_ready=1; holds at 2^CNT_W-1.
REQ-024 Priority: reset > flush > transfer.

Reset
REQ-025 reset=1 at rising edge -> out_valid=0, out_data=0, bubble_cnt=0, skid entry invalid and zero.
REQ-026 in_ready SHALL be 1 in the first cycle after reset release.
REQ-027 Reset mid-operation discards all held entries; no partial-field update.
REQ-028 All registers SHALL also initialise to zero at simulation start.

Configuration
REQ-029 Macro PIPE_STAGE_SKID_EN defined: one-entry skid buffer added; in_ready = !skid_valid (registered, no combinational path from out_ready).
REQ-030 With skid: in transfer while main full and out_ready=0 stores entry in skid; next out transfer moves skid into main register, then skid_valid=0; order preserved.
REQ-031 With skid: flush clears both main and skid entries; latency to output remains 1 cycle when skid empty.
REQ-032 Macro undefined: no skid storage; behaviour per REQ-017 only.

Verification
REQ-033 Reset then in_valid=1, in_data field0=0x8C220004, out_ready=1 -> out_valid=1, field0=0x8C220004 one cycle later.
REQ-034 Stream of 4 entries (0x1..0x4) with out_ready toggling 1,0,1,1,0,1 -> output sequence 0x1,0x2,0x3,0x4 exactly once each, in order.
REQ-035 out_valid=1 holding 0xAAAA5555, flush=1 with in_valid=1 data 0x12345678 -> next cycle out_valid=0, out_data=0.
REQ-036 Reset with out_valid=1, bubble_cnt=7 -> next cycle out_valid=0, out_data=0, bubble_cnt=0, in_ready=1.
REQ-037 CNT_W=4, in_valid=0, out_ready=1 for 20 cycles -> bubble_cnt reaches 15 and holds.
REQ-038 PIPE_STAGE_SKID_EN defined: main=0x1, out_ready=0, accept 0x2 -> in_ready=0 next cycle; out_ready=1 -> outputs 0x1 then 0x2, in_ready=1 again.
